// File: rtl/wrapper_ahb_packet_initiator_if.sv
// Bus bundle for the wrapper AHB packet initiator: AHB-Lite master signals
// plus the source (input word) and sink (result word) stream handshakes.
interface wrapper_ahb_packet_initiator_if;
  logic [31:0] HADDRM;
  logic [1:0]  HTRANSM;
  logic [2:0]  HSIZEM;
  logic        HWRITEM;
  logic [31:0] HWDATAM;
  logic        HREADYM;
  logic        HRESPM;
  logic [31:0] HRDATAM;

  logic [31:0] src_data;
  logic        src_last;
  logic        src_valid;
  logic        src_ready;

  logic [31:0] dst_data;
  logic        dst_last;
  logic        dst_valid;
  logic        dst_ready;

  modport master (
    output HADDRM, HTRANSM, HSIZEM, HWRITEM, HWDATAM,
    input  HREADYM, HRESPM, HRDATAM,
    input  src_data, src_last, src_valid,
    output src_ready,
    output dst_data, dst_last, dst_valid,
    input  dst_ready
  );

  modport slave (
    input  HADDRM, HTRANSM, HSIZEM, HWRITEM, HWDATAM,
    output HREADYM, HRESPM, HRDATAM,
    output src_data, src_last, src_valid,
    input  src_ready,
    input  dst_data, dst_last, dst_valid,
    output dst_ready
  );
endinterface

// File: rtl/wrapper_ahb_packet_initiator.sv
// Non-pipelined AHB-Lite initiator moving packets into/out of an accelerator wrapper.
// Optional packet/stall counters are enabled by defining WRAPPER_INITIATOR_PERF_CNT_EN.
module wrapper_ahb_packet_initiator #(
  parameter int unsigned ADDRWIDTH      = 12,
  parameter int unsigned INPACKETWIDTH  = 512,
  parameter int unsigned OUTPACKETWIDTH = 256,
  parameter logic [31:0] BASEADDR       = 32'h6001_0000
) (
  input  logic HCLK,
  input  logic HRESETn,
  wrapper_ahb_packet_initiator_if.master bus,
  input  logic in_data_req,
  input  logic out_data_req,
  output logic err
`ifdef WRAPPER_INITIATOR_PERF_CNT_EN
  ,
  output logic [31:0] wr_pkt_cnt,
  output logic [31:0] rd_pkt_cnt,
  output logic [31:0] stall_cnt
);
`else
);
`endif

  localparam int unsigned INWORDS  = INPACKETWIDTH / 32;
  localparam int unsigned OUTWORDS = OUTPACKETWIDTH / 32;
  localparam int unsigned MAXWORDS = (INWORDS > OUTWORDS) ? INWORDS : OUTWORDS;
  localparam int unsigned IDXW     = $clog2(MAXWORDS);
  localparam int unsigned BUFW     = $clog2(INWORDS);
  localparam int unsigned WCW      = $clog2(INWORDS + 1);

  localparam logic [31:0]     OUT_OFF     = 32'(1) << (ADDRWIDTH - 1);
  localparam logic [31:0]     WR_LAST_OFF = OUT_OFF - 32'(INPACKETWIDTH / 8);
  localparam logic [IDXW-1:0] IN_LAST     = IDXW'(INWORDS - 1);
  localparam logic [IDXW-1:0] OUT_LAST    = IDXW'(OUTWORDS - 1);
  localparam logic [WCW-1:0]  WC_FULL     = WCW'(INWORDS);
  localparam logic [WCW-1:0]  WC_LAST     = WCW'(INWORDS - 1);
  localparam logic [1:0]      TR_IDLE     = 2'b00;
  localparam logic [1:0]      TR_NONSEQ   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_A, S_WR_D, S_RD_A, S_RD_D, S_RD_HOLD
  } state_t;

  state_t          state;
  logic [31:0]     buffer [INWORDS];
  logic [WCW-1:0]  wcnt;
  logic            pkt_last;
  logic [IDXW-1:0] idx;
  logic            full;
  logic            src_fire;

  assign full       = (wcnt == WC_FULL);
  assign src_fire   = bus.src_valid && bus.src_ready;
  assign bus.HSIZEM = 3'b010;

  // A packet flagged last is placed at the top of the input region so the
  // wrapper can decode end-of-message from the address alone.
  function automatic logic [31:0] wr_addr(input logic [IDXW-1:0] i, input logic lst);
    return BASEADDR + (lst ? WR_LAST_OFF : 32'd0) + 32'({i, 2'b00});
  endfunction

  function automatic logic [31:0] rd_addr(input logic [IDXW-1:0] i);
    return BASEADDR + OUT_OFF + 32'({i, 2'b00});
  endfunction

  always_ff @(posedge HCLK) begin
    if (src_fire) buffer[wcnt[BUFW-1:0]] <= bus.src_data;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state         <= S_IDLE;
      bus.HADDRM    <= BASEADDR;
      bus.HTRANSM   <= TR_IDLE;
      bus.HWRITEM   <= 1'b0;
      bus.HWDATAM   <= '0;
      bus.src_ready <= 1'b0;
      bus.dst_data  <= '0;
      bus.dst_valid <= 1'b0;
      bus.dst_last  <= 1'b0;
      err           <= 1'b0;
      wcnt          <= '0;
      pkt_last      <= 1'b0;
      idx           <= '0;
    end else begin
      if (src_fire) begin
        wcnt <= wcnt + 1'b1;
        if (wcnt == WC_LAST) begin
          pkt_last      <= bus.src_last;
          bus.src_ready <= 1'b0;
        end
      end else begin
        bus.src_ready <= !full;
      end

      case (state)
        S_IDLE: begin
          // Reads go first so a wrapper holding results is never starved.
          if (out_data_req) begin
            bus.HTRANSM <= TR_NONSEQ;
            bus.HWRITEM <= 1'b0;
            bus.HADDRM  <= rd_addr('0);
            state       <= S_RD_A;
          end else if (full && in_data_req) begin
            bus.HTRANSM <= TR_NONSEQ;
            bus.HWRITEM <= 1'b1;
            bus.HADDRM  <= wr_addr('0, pkt_last);
            state       <= S_WR_A;
          end
        end
        S_WR_A: begin
          bus.HTRANSM <= TR_IDLE;
          bus.HWDATAM <= buffer[idx[BUFW-1:0]];
          state       <= S_WR_D;
        end
        S_WR_D: begin
          if (bus.HRESPM) begin
            err   <= 1'b1;
            idx   <= '0;
            state <= S_IDLE;
          end else if (bus.HREADYM) begin
            if (idx == IN_LAST) begin
              idx      <= '0;
              wcnt     <= '0;
              pkt_last <= 1'b0;
              state    <= S_IDLE;
            end else begin
              idx         <= idx + 1'b1;
              bus.HTRANSM <= TR_NONSEQ;
              bus.HADDRM  <= wr_addr(idx + 1'b1, pkt_last);
              state       <= S_WR_A;
            end
          end
        end
        S_RD_A: begin
          bus.HTRANSM <= TR_IDLE;
          state       <= S_RD_D;
        end
        S_RD_D: begin
          if (bus.HRESPM) begin
            err   <= 1'b1;
            idx   <= '0;
            state <= S_IDLE;
          end else if (bus.HREADYM) begin
            bus.dst_data  <= bus.HRDATAM;
            bus.dst_valid <= 1'b1;
            bus.dst_last  <= (idx == OUT_LAST);
            state         <= S_RD_HOLD;
          end
        end
        S_RD_HOLD: begin
          if (bus.dst_ready) begin
            bus.dst_valid <= 1'b0;
            bus.dst_last  <= 1'b0;
            if (idx == OUT_LAST) begin
              idx   <= '0;
              state <= S_IDLE;
            end else begin
              idx         <= idx + 1'b1;
              bus.HTRANSM <= TR_NONSEQ;
              bus.HADDRM  <= rd_addr(idx + 1'b1);
              state       <= S_RD_A;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef WRAPPER_INITIATOR_PERF_CNT_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_pkt_cnt <= '0;
      rd_pkt_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (state == S_WR_D && bus.HREADYM && !bus.HRESPM && idx == IN_LAST)
        wr_pkt_cnt <= wr_pkt_cnt + 32'd1;
      if (state == S_RD_HOLD && bus.dst_ready && idx == OUT_LAST)
        rd_pkt_cnt <= rd_pkt_cnt + 32'd1;
      if ((state == S_WR_D || state == S_RD_D) && !bus.HREADYM)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_wrapper_ahb_packet_initiator.sv
// Directed bench for wrapper_ahb_packet_initiator: fill/write, last-packet
// addressing, reads with sink backpressure, priority, wait states, error, reset.
module tb_wrapper_ahb_packet_initiator;
  logic HCLK;
  logic HRESETn;
  logic in_data_req;
  logic out_data_req;
  logic err;
`ifdef WRAPPER_INITIATOR_PERF_CNT_EN
  logic [31:0] wr_pkt_cnt, rd_pkt_cnt, stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  wrapper_ahb_packet_initiator_if bus ();

  wrapper_ahb_packet_initiator dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .bus          (bus),
    .in_data_req  (in_data_req),
    .out_data_req (out_data_req),
    .err          (err)
`ifdef WRAPPER_INITIATOR_PERF_CNT_EN
    ,
    .wr_pkt_cnt   (wr_pkt_cnt),
    .rd_pkt_cnt   (rd_pkt_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_nonseq();
    int n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (bus.HTRANSM !== 2'b10 && n < 200);
    chk("nonseq_wait", 32'(bus.HTRANSM), 32'h2);
  endtask

  task automatic push(input logic [31:0] d0, input int last_w);
    for (int i = 0; i < 16; i++) begin
      int n = 0;
      bus.src_data  = d0 + 32'(i);
      bus.src_last  = (i == last_w);
      bus.src_valid = 1'b1;
      while (bus.src_ready !== 1'b1 && n < 100) begin
        @(negedge HCLK);
        n++;
      end
      chk("src_ready", 32'(bus.src_ready), 32'h1);
      @(negedge HCLK);
    end
    bus.src_valid = 1'b0;
    bus.src_last  = 1'b0;
    chk("full_ready", 32'(bus.src_ready), 32'h0);
  endtask

  task automatic wr_packet(input logic [31:0] base, input logic [31:0] d0,
                           input int stall_w, input int err_w);
    for (int i = 0; i < 16; i++) begin
      wait_nonseq();
      chk("wr_addr", bus.HADDRM, base + 32'(4 * i));
      chk("wr_write", 32'(bus.HWRITEM), 32'h1);
      @(negedge HCLK);
      chk("wr_trans_dp", 32'(bus.HTRANSM), 32'h0);
      chk("wr_data", bus.HWDATAM, d0 + 32'(i));
      if (i == err_w) begin
        bus.HRESPM = 1'b1;
        @(negedge HCLK);
        bus.HRESPM = 1'b0;
        chk("err_set", 32'(err), 32'h1);
        chk("err_idle", 32'(bus.HTRANSM), 32'h0);
        return;
      end
      if (i == stall_w) begin
        bus.HREADYM = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge HCLK);
          chk("stall_data", bus.HWDATAM, d0 + 32'(i));
          chk("stall_addr", bus.HADDRM, base + 32'(4 * i));
          chk("stall_trans", 32'(bus.HTRANSM), 32'h0);
        end
        bus.HREADYM = 1'b1;
      end
    end
  endtask

  task automatic rd_packet(input bit toggle);
    out_data_req  = 1'b1;
    bus.dst_ready = !toggle;
    for (int i = 0; i < 8; i++) begin
      wait_nonseq();
      bus.dst_ready = !toggle;
      chk("rd_addr", bus.HADDRM, 32'h6001_0800 + 32'(4 * i));
      chk("rd_write", 32'(bus.HWRITEM), 32'h0);
      if (i == 0) out_data_req = 1'b0;
      bus.HRDATAM = 32'hA0 + 32'(i);
      @(negedge HCLK);
      chk("rd_valid_dp", 32'(bus.dst_valid), 32'h0);
      @(negedge HCLK);
      chk("rd_valid", 32'(bus.dst_valid), 32'h1);
      chk("rd_data", bus.dst_data, 32'hA0 + 32'(i));
      chk("rd_last", 32'(bus.dst_last), (i == 7) ? 32'h1 : 32'h0);
      if (toggle) begin
        @(negedge HCLK);
        chk("rd_hold_data", bus.dst_data, 32'hA0 + 32'(i));
        chk("rd_hold_valid", 32'(bus.dst_valid), 32'h1);
        bus.dst_ready = 1'b1;
      end
    end
    @(negedge HCLK);
    chk("rd_end_valid", 32'(bus.dst_valid), 32'h0);
    chk("rd_end_trans", 32'(bus.HTRANSM), 32'h0);
    bus.dst_ready = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_haddr", bus.HADDRM, 32'h6001_0000);
    chk("rst_htrans", 32'(bus.HTRANSM), 32'h0);
    chk("rst_hsize", 32'(bus.HSIZEM), 32'h2);
    chk("rst_hwrite", 32'(bus.HWRITEM), 32'h0);
    chk("rst_hwdata", bus.HWDATAM, 32'h0);
    chk("rst_src_ready", 32'(bus.src_ready), 32'h0);
    chk("rst_dst_valid", 32'(bus.dst_valid), 32'h0);
    chk("rst_dst_last", 32'(bus.dst_last), 32'h0);
    chk("rst_dst_data", bus.dst_data, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
  endtask

  initial begin
    HRESETn       = 1'b0;
    in_data_req   = 1'b0;
    out_data_req  = 1'b0;
    bus.HREADYM   = 1'b1;
    bus.HRESPM    = 1'b0;
    bus.HRDATAM   = '0;
    bus.src_data  = '0;
    bus.src_last  = 1'b0;
    bus.src_valid = 1'b0;
    bus.dst_ready = 1'b0;

    repeat (2) @(negedge HCLK);
    chk_reset_vals();
    HRESETn = 1'b1;
    @(negedge HCLK);
    chk("fill_ready", 32'(bus.src_ready), 32'h1);

    // Non-last packet; src_last on word 7 must be ignored.
    push(32'h0, 7);
    in_data_req = 1'b1;
    wr_packet(32'h6001_0000, 32'h0, -1, -1);
    in_data_req = 1'b0;
    repeat (2) @(negedge HCLK);
    chk("cleared_ready", 32'(bus.src_ready), 32'h1);

    // Last packet lands at the top of the input region.
    push(32'h100, 15);
    in_data_req = 1'b1;
    wr_packet(32'h6001_07C0, 32'h100, -1, -1);
    in_data_req = 1'b0;

    // Read with sink backpressure.
    rd_packet(1'b1);

    // Both requests together: read wins, then write follows.
    push(32'h200, 99);
    in_data_req = 1'b1;
    rd_packet(1'b0);
    wr_packet(32'h6001_0000, 32'h200, -1, -1);
    in_data_req = 1'b0;

    // Three wait states on word 5.
    push(32'h300, 99);
    in_data_req = 1'b1;
    wr_packet(32'h6001_0000, 32'h300, 5, -1);
    in_data_req = 1'b0;
`ifdef WRAPPER_INITIATOR_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, 32'd3);
    chk("wr_pkt_cnt", wr_pkt_cnt, 32'd4);
    chk("rd_pkt_cnt", rd_pkt_cnt, 32'd2);
`endif

    // Error on word 2, then the whole packet is resent from word 0.
    push(32'h400, 99);
    in_data_req = 1'b1;
    wr_packet(32'h6001_0000, 32'h400, -1, 2);
    wr_packet(32'h6001_0000, 32'h400, -1, -1);
    in_data_req = 1'b0;
    chk("err_sticky", 32'(err), 32'h1);

    // Reset in the middle of a read.
    out_data_req = 1'b1;
    wait_nonseq();
    chk("mid_rd_addr", bus.HADDRM, 32'h6001_0800);
    out_data_req = 1'b0;
    bus.HRDATAM  = 32'hB0;
    @(negedge HCLK);
    @(negedge HCLK);
    chk("mid_rd_valid", 32'(bus.dst_valid), 32'h1);
    HRESETn = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);
    chk("post_rst_ready", 32'(bus.src_ready), 32'h1);
    chk("post_rst_trans", 32'(bus.HTRANSM), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wrapper_ahb_packet_initiator.md
Name: wrapper_ahb_packet_initiator

Overview:
- AHB-Lite initiator that drives an accelerator wrapper's AHB target from the bus-master side.
- Collects 32-bit words from a source stream into input packets and writes each packet into the wrapper's input port region when in_data_req is high.
- Reads result packets from the output port region when out_data_req is high and presents them as a 32-bit sink stream.
- Serves as the DMA stand-in for testbenches and simple SoC integration.

Parameters:
- ADDRWIDTH, 12: wrapper address space width. Input region has bit ADDRWIDTH-1 = 0; output region has it = 1.
- INPACKETWIDTH, 512: input packet width. INWORDS = INPACKETWIDTH/32.
- OUTPACKETWIDTH, 256: output packet width. OUTWORDS = OUTPACKETWIDTH/32.
- BASEADDR, 32'h6001_0000: wrapper base address, ADDRWIDTH-aligned.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- HADDRM  out  32  AHB address
- HTRANSM  out  2  IDLE (00) or NONSEQ (10) only
- HSIZEM  out  3  fixed 3'b010 (word)
- HWRITEM  out  1  write enable
- HWDATAM  out  32  write data
- HREADYM  in  1  transfer ready
- HRESPM  in  1  error response
- HRDATAM  in  32  read data
- in_data_req  in  1  wrapper can accept an input packet
- out_data_req  in  1  wrapper holds an output packet
- src_data  in  32  source word
- src_last  in  1  final word of message
- src_valid  in  1  source handshake
- src_ready  out  1  source handshake
- dst_data  out  32  result word
- dst_last  out  1  final word of output packet
- dst_valid  out  1  sink handshake
- dst_ready  in  1  sink handshake
- err  out  1  sticky bus-error flag

Behaviour:
- Clock and reset: single clock HCLK. HRESETn is asynchronous assert, active-low.
- Reset values: HTRANSM=IDLE, HADDRM=BASEADDR, HWRITEM=0, HWDATAM=0, src_ready=0, dst_valid=0, dst_last=0, dst_data=0, err=0. All counters 0, state FILL.
- Fill path:
  - src_ready=1 in FILL while the buffer is not full.
  - Each src handshake stores a word at buffer[wcnt] and increments wcnt.
  - The last flag is captured from src_last on word INWORDS-1. src_last on earlier words is ignored; messages are packet-aligned.
  - When wcnt reaches INWORDS, the buffer is full and src_ready=0.
- State machine, non-pipelined (every transfer is an address phase followed by a data phase with HTRANSM=IDLE):
  - IDLE: if out_data_req=1, go to RD_A. Read has priority, to avoid wrapper deadlock.
  - IDLE: else if the buffer is full and in_data_req=1, go to WR_A.
  - WR_A: NONSEQ, HWRITEM=1, address as defined below. Then go to WR_D.
  - WR_D: HWDATAM=buffer[idx]. Hold while HREADYM=0. On HREADYM=1, idx++. When idx wraps past INWORDS-1, clear the buffer, return to IDLE (FILL resumes); otherwise go to WR_A.
  - RD_A: NONSEQ, HWRITEM=0, address = BASEADDR + 2^(ADDRWIDTH-1) + 4*idx. Then go to RD_D.
  - RD_D: on HREADYM=1, capture HRDATAM into dst_data and set dst_valid=1, with dst_last=(idx==OUTWORDS-1). Go to RD_HOLD.
  - RD_HOLD: wait for dst_ready. Then idx++; go to RD_A, or to IDLE after the last word.
- Write address:
  - Non-last packet: BASEADDR + 4*idx.
  - Packet with last captured: BASEADDR + (2^(ADDRWIDTH-1) - INPACKETWIDTH/8) + 4*idx, i.e. the packet sits at the top of the input region. The packet constructor decodes this position as last.
- Latency: INWORDS×2 cycles minimum per write packet; OUTWORDS×3 cycles minimum per read packet.
- Error: HRESPM=1 in a data phase sets err (cleared only by reset), abandons the current packet, and returns to IDLE. An abandoned write keeps the buffer full, so the packet is retried on the next in_data_req.
- Reset mid-transfer: outputs return to reset values immediately; buffer contents are discarded.
- in_data_req or out_data_req deasserting mid-packet has no effect; the packet completes.

Optional Feature:
- Macro: WRAPPER_INITIATOR_PERF_CNT_EN.
- When defined, adds these outputs:
  - wr_pkt_cnt[31:0]: increments on each completed write packet.
  - rd_pkt_cnt[31:0]: increments on each completed read packet.
  - stall_cnt[31:0]: increments each data-phase cycle with HREADYM=0.
  - All three reset to 0 and wrap at 2^32.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Write, non-last: 16 words 0x00..0x0F with src_last=0, in_data_req=1, HREADYM=1 → 16 writes at 0x6001_0000..0x6001_003C, data 0x00..0x0F, buffer cleared.
- Write, last: 16 words with src_last on word 15 → writes at 0x6001_07C0..0x6001_07FC.
- Read: out_data_req=1, HRDATAM=0xA0+idx → 8 reads at 0x6001_0800..0x6001_081C; dst_data 0xA0..0xA7, dst_last only on 0xA7. dst_ready toggled 1/0 → no word lost or duplicated.
- Priority: buffer full with in_data_req=1 and out_data_req=1 in the same cycle → read packet first, then write.
- Wait states: HREADYM=0 for 3 cycles on write word 5 → HWDATAM held, no address advance; stall_cnt=3 when WRAPPER_INITIATOR_PERF_CNT_EN is defined.
- Error and reset: HRESPM=1 on write word 2 → err=1, state IDLE, same packet re-sent from word 0. Then HRESETn pulsed low mid-read → all outputs at reset values, err=0.
